// File: rtl/cache_pkg.sv
// Cache-side types: enable/status packets and the write-buffer entry.
package cache_pkg;

    // Buffer entries carry a fixed-width address; narrower controllers zero-extend.
    localparam int unsigned ENTRY_ADDR_WIDTH = 32;

    typedef struct packed {
        logic data;
        logic dirty;
        logic valid;
    } data_enable_t;

    typedef struct packed {
        logic dirty;
        logic valid;
    } status_packet_t;

    typedef struct packed {
        logic [ENTRY_ADDR_WIDTH-1:0] addr;
        logic [31:0]                 data;
        logic [3:0]                  byte_en;
    } write_buffer_entry_t;

endpackage

// File: rtl/store_unit_pkg.sv
// Store-unit types shared by everything that consumes store requests.
package store_unit_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } store_width_t;

endpackage

// File: rtl/write_merge_controller_pkg.sv
// FSM state types and byte-lane alignment helpers for write_merge_controller.
package write_merge_controller_pkg;
    import store_unit_pkg::*;

    typedef enum logic {
        IDLE    = 1'b0,
        OUTCOME = 1'b1
    } store_state_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_WAIT = 1'b1
    } drain_state_t;

    function automatic logic [3:0] lane_mask(input store_width_t w, input logic [1:0] off);
        case (w)
            BYTE:      return 4'b0001 << off;
            HALF_WORD: return off[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] align_data(input store_width_t w, input logic [1:0] off,
                                               input logic [31:0] d);
        case (w)
            BYTE:      return d << {off, 3'b000};
            HALF_WORD: return d << {off[1], 4'b0000};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/write_buffer.sv
// Circular store FIFO (DEPTH a power of two). With WRITE_MERGE_EN defined it also
// exposes a lookup/merge port that folds a store into a matching non-head entry.
module write_buffer
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                i_push,
    input  write_buffer_entry_t i_entry,
    input  logic                i_pop,
`ifdef WRITE_MERGE_EN
    input  logic                i_merge,
    output logic                o_lookup_hit,
`endif
    output write_buffer_entry_t o_head,
    output logic                o_full,
    output logic                o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ENTRY_ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [31:0]                 r_data [DEPTH];
    logic [3:0]                  r_byte [DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]            r_count, w_count_next;
    logic                        r_full, r_empty;
    logic                        w_push, w_pop;
    logic [DEPTH-1:0]            w_merge_sel;
    logic [31:0]                 w_lane_bits;

    assign w_push       = i_push && !r_full;
    assign w_pop        = i_pop && !r_empty;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_lane_bits  = {{8{i_entry.byte_en[3]}}, {8{i_entry.byte_en[2]}},
                           {8{i_entry.byte_en[1]}}, {8{i_entry.byte_en[0]}}};

`ifdef WRITE_MERGE_EN
    logic [DEPTH-1:0] w_match;
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        // Head is never a merge target: it is in flight or being launched this cycle.
        assign w_match[gi] = (r_byte[gi] != 4'b0000) && (r_addr[gi] == i_entry.addr)
                          && (r_rd_ptr != PTR_W'(gi));
    end
    assign o_lookup_hit = |w_match;
    assign w_merge_sel  = i_merge ? w_match : '0;
`else
    assign w_merge_sel  = '0;
`endif

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && r_wr_ptr == PTR_W'(i)) begin
                r_addr[i] <= i_entry.addr;
                r_data[i] <= i_entry.data;
            end else if (w_merge_sel[i]) begin
                r_data[i] <= (r_data[i] & ~w_lane_bits) | (i_entry.data & w_lane_bits);
            end
        end
    end

    // A non-zero byte mask doubles as the entry-valid flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) r_byte[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && r_wr_ptr == PTR_W'(i))       r_byte[i] <= i_entry.byte_en;
                else if (w_merge_sel[i])                    r_byte[i] <= r_byte[i] | i_entry.byte_en;
                else if (w_pop && r_rd_ptr == PTR_W'(i))    r_byte[i] <= '0;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == DEPTH_CNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_head  = '{addr: r_addr[r_rd_ptr], data: r_data[r_rd_ptr], byte_en: r_byte[r_rd_ptr]};
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/write_merge_controller.sv
// Store retirement with a posted write buffer draining to memory.
// Define WRITE_MERGE_EN to merge misses into a matching buffered word.
module write_merge_controller
    import store_unit_pkg::*;
    import cache_pkg::*;
    import write_merge_controller_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  halt_i,
    input  logic                  request_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [31:0]           data_i,
    input  store_width_t          width_i,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic                  cache_hit_i,
    input  logic                  cache_dirty_i,
    output data_enable_t          cache_read_o,
    output data_enable_t          cache_write_o,
    output status_packet_t        cache_status_o,
    output logic [3:0]            cache_byte_o,
    output logic [ADDR_WIDTH-1:0] cache_address_o,
    output logic [31:0]           cache_data_o,
    output logic                  mem_request_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [31:0]           mem_data_o,
    output logic [3:0]            mem_byte_o,
    input  logic                  mem_done_i
);
    store_state_t          r_store_state, w_store_next;
    drain_state_t          r_drain_state, w_drain_next;
    logic                  w_accept, w_enqueue, w_push, w_launch, w_pop, w_full, w_empty;
    logic [ADDR_WIDTH-1:0] r_st_addr;
    logic [31:0]           r_st_data;
    store_width_t          r_st_width;
    logic [3:0]            w_lane;
    logic [31:0]           w_aligned;
    write_buffer_entry_t   w_new_entry, w_head;

    logic                  r_valid, r_mem_request;
    data_enable_t          r_cache_read, r_cache_write;
    status_packet_t        r_cache_status;
    logic [3:0]            r_cache_byte, r_mem_byte;
    logic [ADDR_WIDTH-1:0] r_cache_address, r_mem_address;
    logic [31:0]           r_cache_data, r_mem_data;

    assign w_lane      = lane_mask(r_st_width, r_st_addr[1:0]);
    assign w_aligned   = align_data(r_st_width, r_st_addr[1:0], r_st_data);
    assign w_new_entry = '{addr: ENTRY_ADDR_WIDTH'({r_st_addr[ADDR_WIDTH-1:2], 2'b00}),
                           data: w_aligned, byte_en: w_lane};

    always_comb begin
        w_store_next = r_store_state;
        w_accept     = 1'b0;
        w_enqueue    = 1'b0;
        if (!halt_i) begin
            case (r_store_state)
                IDLE: if (request_i && !w_full) begin
                    w_accept     = 1'b1;
                    w_store_next = OUTCOME;
                end
                OUTCOME: begin
                    w_enqueue    = !cache_hit_i;
                    w_store_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_drain_next = r_drain_state;
        w_launch     = 1'b0;
        w_pop        = 1'b0;
        if (!halt_i) begin
            case (r_drain_state)
                DRAIN_IDLE: if (!w_empty) begin
                    w_launch     = 1'b1;
                    w_drain_next = DRAIN_WAIT;
                end
                DRAIN_WAIT: if (mem_done_i) begin
                    w_pop        = 1'b1;
                    w_drain_next = DRAIN_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_store_state <= IDLE;
            r_drain_state <= DRAIN_IDLE;
        end else begin
            r_store_state <= w_store_next;
            r_drain_state <= w_drain_next;
        end
    end

    // All outputs are registered so that halt holds them and reset clears them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_st_addr       <= '0;
            r_st_data       <= '0;
            r_st_width      <= BYTE;
            r_valid         <= 1'b0;
            r_cache_read    <= '0;
            r_cache_write   <= '0;
            r_cache_status  <= '0;
            r_cache_byte    <= '0;
            r_cache_address <= '0;
            r_cache_data    <= '0;
            r_mem_request   <= 1'b0;
            r_mem_address   <= '0;
            r_mem_data      <= '0;
            r_mem_byte      <= '0;
        end else if (!halt_i) begin
            r_valid        <= 1'b0;
            r_cache_read   <= '0;
            r_cache_write  <= '0;
            r_cache_status <= '0;
            if (w_accept) begin
                r_st_addr       <= address_i;
                r_st_data       <= data_i;
                r_st_width      <= width_i;
                r_cache_read    <= '1;
                r_cache_address <= address_i;
            end
            if (r_store_state == OUTCOME) begin
                r_valid      <= 1'b1;
                r_cache_byte <= w_lane;
                r_cache_data <= w_aligned;
                if (cache_hit_i) begin
                    r_cache_write  <= '1;
                    r_cache_status <= '1;
                end else if (!cache_dirty_i) begin
                    r_cache_write.valid <= 1'b1;
                end
            end
            r_mem_request <= w_launch;
            if (w_launch) begin
                r_mem_address <= w_head.addr[ADDR_WIDTH-1:0];
                r_mem_data    <= w_head.data;
                r_mem_byte    <= w_head.byte_en;
            end
        end
    end

`ifdef WRITE_MERGE_EN
    logic w_lookup_hit;
    assign w_push = w_enqueue && !w_lookup_hit;
`else
    assign w_push = w_enqueue;
`endif

    write_buffer #(.DEPTH(DEPTH)) u_write_buffer (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .i_push       (w_push),
        .i_entry      (w_new_entry),
        .i_pop        (w_pop),
`ifdef WRITE_MERGE_EN
        .i_merge      (w_enqueue && w_lookup_hit),
        .o_lookup_hit (w_lookup_hit),
`endif
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    assign valid_o         = r_valid;
    assign full_o          = w_full;
    assign empty_o         = w_empty;
    assign cache_read_o    = r_cache_read;
    assign cache_write_o   = r_cache_write;
    assign cache_status_o  = r_cache_status;
    assign cache_byte_o    = r_cache_byte;
    assign cache_address_o = r_cache_address;
    assign cache_data_o    = r_cache_data;
    assign mem_request_o   = r_mem_request;
    assign mem_address_o   = r_mem_address;
    assign mem_data_o      = r_mem_data;
    assign mem_byte_o      = r_mem_byte;

endmodule

// File: tb/tb_write_merge_controller.sv
// Directed bench for write_merge_controller: hit, miss, full, merge, collision, reset, halt.
module tb_write_merge_controller;
    import store_unit_pkg::*;
    import cache_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_n_i = 1'b1;
    logic           halt_i = 1'b0;
    logic           request_i = 1'b0;
    logic [31:0]    address_i = '0;
    logic [31:0]    data_i = '0;
    store_width_t   width_i = BYTE;
    logic           cache_hit_i = 1'b0;
    logic           cache_dirty_i = 1'b0;
    logic           mem_done_i = 1'b0;
    logic           valid_o, full_o, empty_o, mem_request_o;
    data_enable_t   cache_read_o, cache_write_o;
    status_packet_t cache_status_o;
    logic [3:0]     cache_byte_o, mem_byte_o;
    logic [31:0]    cache_address_o, cache_data_o, mem_address_o, mem_data_o;

    int n_checks = 0;
    int n_errors = 0;
    int base;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_byte[$];

    write_merge_controller #(.DEPTH(4), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .halt_i(halt_i), .request_i(request_i),
        .address_i(address_i), .data_i(data_i), .width_i(width_i),
        .valid_o(valid_o), .full_o(full_o), .empty_o(empty_o),
        .cache_hit_i(cache_hit_i), .cache_dirty_i(cache_dirty_i),
        .cache_read_o(cache_read_o), .cache_write_o(cache_write_o),
        .cache_status_o(cache_status_o), .cache_byte_o(cache_byte_o),
        .cache_address_o(cache_address_o), .cache_data_o(cache_data_o),
        .mem_request_o(mem_request_o), .mem_address_o(mem_address_o),
        .mem_data_o(mem_data_o), .mem_byte_o(mem_byte_o), .mem_done_i(mem_done_i)
    );

    always #5 clk_i = ~clk_i;

    // Record every memory write request as it is presented.
    always @(negedge clk_i) begin
        if (mem_request_o) begin
            log_addr.push_back(mem_address_o);
            log_data.push_back(mem_data_o);
            log_byte.push_back(mem_byte_o);
            $display("mem write: addr=%h data=%h byte=%b", mem_address_o, mem_data_o, mem_byte_o);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b);
        if (idx < log_addr.size()) begin
            check({tag, "_addr"}, 64'(log_addr[idx]), 64'(a));
            check({tag, "_data"}, 64'(log_data[idx]), 64'(d));
            check({tag, "_byte"}, 64'(log_byte[idx]), 64'(b));
        end else begin
            check({tag, "_present"}, 64'(log_addr.size()), 64'(idx + 1));
        end
    endtask

    // Present one store; returns #1 after the retire edge (valid_o visible).
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input store_width_t w,
                            input logic hit, input logic dirty, input logic done);
        request_i = 1'b1; address_i = a; data_i = d; width_i = w;
        tick();
        request_i = 1'b0; cache_hit_i = hit; cache_dirty_i = dirty; mem_done_i = done;
        check("accept_read", 64'(cache_read_o), 64'(3'b111));
        check("accept_no_valid", 64'(valid_o), 64'(0));
        tick();
        mem_done_i = 1'b0;
        check("retire_valid", 64'(valid_o), 64'(1));
        $display("store addr=%h data=%h hit=%0d retired", a, d, hit);
    endtask

    task automatic drain_all(input string tag);
        int cyc;
        cyc = 0;
        mem_done_i = 1'b1;
        while (!empty_o && cyc < 40) begin
            tick();
            cyc++;
        end
        mem_done_i = 1'b0;
        check({tag, "_drained"}, 64'(empty_o), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset, checked before any clock edge
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_empty", 64'(empty_o), 64'(1));
        check("rst_full", 64'(full_o), 64'(0));
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_mem_req", 64'(mem_request_o), 64'(0));
        check("rst_cache_read", 64'(cache_read_o), 64'(0));
        tick();
        tick();
        rst_n_i = 1'b1;

        // Hit: WORD 0x1000
        do_store(32'h1000, 32'hDEADBEEF, WORD, 1'b1, 1'b0, 1'b0);
        check("hit_byte", 64'(cache_byte_o), 64'(4'b1111));
        check("hit_data", 64'(cache_data_o), 64'(32'hDEADBEEF));
        check("hit_addr", 64'(cache_address_o), 64'(32'h1000));
        check("hit_write", 64'(cache_write_o), 64'(3'b111));
        check("hit_status", 64'(cache_status_o), 64'(2'b11));
        check("hit_empty", 64'(empty_o), 64'(1));
        tick();
        check("hit_valid_pulse", 64'(valid_o), 64'(0));
        check("hit_no_mem", 64'(log_addr.size()), 64'(0));

        // Miss: BYTE 0x1003 clean -> invalidate, enqueue, drain
        do_store(32'h1003, 32'h000000AB, BYTE, 1'b0, 1'b0, 1'b0);
        check("miss_write", 64'(cache_write_o), 64'(3'b001));
        check("miss_status", 64'(cache_status_o), 64'(2'b00));
        check("miss_byte", 64'(cache_byte_o), 64'(4'b1000));
        check("miss_data", 64'(cache_data_o), 64'(32'hAB000000));
        check("miss_not_empty", 64'(empty_o), 64'(0));
        tick();
        check("miss_mem_req", 64'(mem_request_o), 64'(1));
        check("miss_mem_addr", 64'(mem_address_o), 64'(32'h1000));
        check("miss_mem_data", 64'(mem_data_o), 64'(32'hAB000000));
        check("miss_mem_byte", 64'(mem_byte_o), 64'(4'b1000));
        tick();
        check("miss_req_pulse", 64'(mem_request_o), 64'(0));
        check("miss_addr_hold", 64'(mem_address_o), 64'(32'h1000));
        mem_done_i = 1'b1;
        tick();
        mem_done_i = 1'b0;
        check("miss_popped", 64'(empty_o), 64'(1));

        // Full: four misses fill the buffer, the fifth waits for one mem_done_i
        do_store(32'h3000, 32'h1, WORD, 1'b0, 1'b1, 1'b0);
        do_store(32'h3004, 32'h2, WORD, 1'b0, 1'b1, 1'b0);
        do_store(32'h3008, 32'h3, WORD, 1'b0, 1'b1, 1'b0);
        check("full_after3", 64'(full_o), 64'(0));
        do_store(32'h300C, 32'h4, WORD, 1'b0, 1'b1, 1'b0);
        check("full_after4", 64'(full_o), 64'(1));
        request_i = 1'b1; address_i = 32'h3010; data_i = 32'h5; width_i = WORD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_blocks", 64'(cache_read_o), 64'(0));
        end
        mem_done_i = 1'b1;
        tick();
        mem_done_i = 1'b0;
        check("full_cleared", 64'(full_o), 64'(0));
        check("full_still_blocked", 64'(cache_read_o), 64'(0));
        tick();
        request_i = 1'b0;
        check("full_accept", 64'(cache_read_o), 64'(3'b111));
        check("full_next_req", 64'(mem_request_o), 64'(1));
        check("full_next_addr", 64'(mem_address_o), 64'(32'h3004));
        tick();
        check("full_fifth_valid", 64'(valid_o), 64'(1));
        check("full_again", 64'(full_o), 64'(1));
        drain_all("full");
        check("order_count", 64'(log_addr.size()), 64'(6));
        check_log("order0", 0, 32'h1000, 32'hAB000000, 4'b1000);
        for (int i = 1; i < 6; i++)
            check_log("order", i, 32'h3000 + 32'((i - 1) * 4), 32'(i), 4'b1111);

        // Merge: two halves of 0x2000 while the drain is busy with 0x4000
        base = log_addr.size();
        do_store(32'h4000, 32'h55, WORD, 1'b0, 1'b1, 1'b0);
        do_store(32'h2000, 32'h1111, HALF_WORD, 1'b0, 1'b1, 1'b0);
        do_store(32'h2002, 32'h2222, HALF_WORD, 1'b0, 1'b1, 1'b0);
        drain_all("merge");
        check_log("merge_head", base, 32'h4000, 32'h55, 4'b1111);
`ifdef WRITE_MERGE_EN
        check("merge_count", 64'(log_addr.size()), 64'(base + 2));
        check_log("merged", base + 1, 32'h2000, 32'h22221111, 4'b1111);
`else
        check("merge_count", 64'(log_addr.size()), 64'(base + 3));
        check_log("half_lo", base + 1, 32'h2000, 32'h00001111, 4'b0011);
        check_log("half_hi", base + 2, 32'h2000, 32'h22220000, 4'b1100);
`endif

        // Enqueue coincident with mem_done_i: occupancy stays at one
        base = log_addr.size();
        do_store(32'h5000, 32'hA, WORD, 1'b0, 1'b1, 1'b0);
        do_store(32'h5004, 32'hB, WORD, 1'b0, 1'b1, 1'b1);
        check("coinc_not_empty", 64'(empty_o), 64'(0));
        check("coinc_not_full", 64'(full_o), 64'(0));
        drain_all("coinc");
        check("coinc_count", 64'(log_addr.size()), 64'(base + 2));
        check_log("coinc0", base, 32'h5000, 32'hA, 4'b1111);
        check_log("coinc1", base + 1, 32'h5004, 32'hB, 4'b1111);

        // Reset in the middle of DRAIN_WAIT, then a late mem_done_i
        base = log_addr.size();
        do_store(32'h6000, 32'hC, WORD, 1'b0, 1'b1, 1'b0);
        do_store(32'h6004, 32'hD, WORD, 1'b0, 1'b1, 1'b0);
        #2 rst_n_i = 1'b0;
        #1;
        check("mrst_empty", 64'(empty_o), 64'(1));
        check("mrst_full", 64'(full_o), 64'(0));
        check("mrst_valid", 64'(valid_o), 64'(0));
        check("mrst_mem_req", 64'(mem_request_o), 64'(0));
        mem_done_i = 1'b1;
        tick();
        rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_done_i = 1'b0;
        check("mrst_no_more_req", 64'(log_addr.size()), 64'(base + 1));
        check("mrst_still_empty", 64'(empty_o), 64'(1));

        // Halt freezes acceptance
        halt_i = 1'b1;
        request_i = 1'b1; address_i = 32'h7000; data_i = 32'h77; width_i = WORD;
        cache_hit_i = 1'b1;
        tick();
        check("halt_no_read", 64'(cache_read_o), 64'(0));
        tick();
        check("halt_no_valid", 64'(valid_o), 64'(0));
        halt_i = 1'b0;
        tick();
        request_i = 1'b0;
        check("halt_release_read", 64'(cache_read_o), 64'(3'b111));
        tick();
        check("halt_release_valid", 64'(valid_o), 64'(1));
        check("halt_release_data", 64'(cache_data_o), 64'(32'h77));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
